spi_flash_reader: RTL and testbench

- Sequencer that drives the SPI byte engine to stream 16-bit words out of the W25Q16BV flash.
- Handles a start request carrying a 24-bit byte address and a word count. For each request it:
  - issues the READ command and the 3 address bytes,
  - clocks out 2×count bytes,
  - assembles each pair big-endian into a word,
  - hands each word downstream via valid/ready.
- Sits between the SPI engine and a loader/bootstrap client (e.g. ROM-from-flash copier), replacing CPU-polled byte I/O.

---
 rtl/spi_flash_defs.sv | 18 +
 rtl/spi_byte_xfer.sv | 48 ++++
 rtl/spi_flash_reader.sv | 120 ++++++++++++
 tb/tb_spi_flash_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_defs.sv
// spi_flash_defs: state/phase encodings and SPI constants shared by the flash reader blocks
package spi_flash_defs;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_DUMMY, S_RD_HI, S_RD_LO, S_PUSH, S_RELEASE
    } state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_ISSUE, PH_GUARD, PH_WAIT} phase_t;

    localparam logic [7:0]  DEF_READ_CMD      = 8'h03;
    localparam logic [7:0]  DEF_FAST_READ_CMD = 8'h0B;
    localparam logic [15:0] CS_RELEASE        = 16'h0100;

    function automatic logic is_xfer(state_t s);
        return s != S_IDLE && s != S_PUSH;
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// spi_byte_xfer: runs one SPI engine load (data byte or CSX release) through issue, guard and wait-for-idle
module spi_byte_xfer
    import spi_flash_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        go_i,
    input  logic        rel_i,
    input  logic [7:0]  byte_i,
    input  logic        spi_busy_i,
    input  logic [7:0]  spi_rx_i,
    output logic        idle_o,
    output logic        load_o,
    output logic [15:0] spi_in_o,
    output logic        done_o,
    output logic [7:0]  rx_o
);

    phase_t      phase_q, phase_d;
    logic [15:0] tx_q, tx_d;

    // phase and outgoing engine word registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            tx_q    <= '0;
        end else begin
            phase_q <= phase_d;
            tx_q    <= tx_d;
        end
    end

    // engine busy is stale right after a load, so one guard cycle passes before it is trusted
    always_comb begin
        phase_d = phase_q == PH_IDLE  ? (go_i ? PH_ISSUE : PH_IDLE)
                : phase_q == PH_ISSUE ? PH_GUARD
                : phase_q == PH_GUARD ? PH_WAIT
                : (spi_busy_i ? PH_WAIT : PH_IDLE);
        tx_d = (phase_q == PH_IDLE && go_i) ? (rel_i ? CS_RELEASE : {8'h00, byte_i}) : tx_q;
    end

    assign idle_o   = phase_q == PH_IDLE;
    assign load_o   = phase_q == PH_ISSUE;
    assign spi_in_o = tx_q;
    assign done_o   = phase_q == PH_WAIT && !spi_busy_i;
    assign rx_o     = spi_rx_i;

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: streams big-endian 16-bit words from a W25Q16BV flash through the SPI byte engine
// Build option SPI_FLASH_FAST_READ_EN: use FAST_READ with one discarded dummy byte after the address
module spi_flash_reader
    import spi_flash_defs::*;
#(
    parameter logic [7:0] READ_CMD      = DEF_READ_CMD,
    parameter logic [7:0] FAST_READ_CMD = DEF_FAST_READ_CMD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        spi_load,
    output logic [15:0] spi_in,
    input  logic [15:0] spi_out
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [7:0] OPCODE = FAST ? FAST_READ_CMD : READ_CMD;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d, word_q, word_d;
    logic        done_q, done_d;
    logic        xgo, xrel, xidle, xdone;
    logic [7:0]  xbyte, xrx;
    logic        unused_spi;

    assign unused_spi = ^spi_out[14:8];

    spi_byte_xfer u_xfer (
        .clk        (clk),
        .reset      (reset),
        .go_i       (xgo),
        .rel_i      (xrel),
        .byte_i     (xbyte),
        .spi_busy_i (spi_out[15]),
        .spi_rx_i   (spi_out[7:0]),
        .idle_o     (xidle),
        .load_o     (spi_load),
        .spi_in_o   (spi_in),
        .done_o     (xdone),
        .rx_o       (xrx)
    );

    // sequencer state register; reset lands in INIT so CSX is released after any reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // latched request, remaining word count, word being assembled and the done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            done_q <= done_d;
        end
    end

    // advance on each completed byte; words are paced by the consumer handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    state_d = xdone ? S_IDLE : S_INIT;
            S_IDLE:    state_d = (start && count != 16'd0) ? S_CMD : S_IDLE;
            S_CMD:     state_d = xdone ? S_ADDR2 : S_CMD;
            S_ADDR2:   state_d = xdone ? S_ADDR1 : S_ADDR2;
            S_ADDR1:   state_d = xdone ? S_ADDR0 : S_ADDR1;
            S_ADDR0:   state_d = xdone ? (FAST ? S_DUMMY : S_RD_HI) : S_ADDR0;
            S_DUMMY:   state_d = xdone ? S_RD_HI : S_DUMMY;
            S_RD_HI:   state_d = xdone ? S_RD_LO : S_RD_HI;
            S_RD_LO:   state_d = xdone ? S_PUSH : S_RD_LO;
            S_PUSH:    state_d = word_ready ? (cnt_q == 16'd1 ? S_RELEASE : S_RD_HI) : S_PUSH;
            S_RELEASE: state_d = xdone ? S_IDLE : S_RELEASE;
            default:   state_d = S_INIT;
        endcase
    end

    // per-state byte selection, status outputs and datapath updates
    always_comb begin
        busy       = state_q != S_INIT && state_q != S_IDLE;
        word_valid = state_q == S_PUSH;
        xgo        = is_xfer(state_q) && xidle;
        xrel       = state_q == S_INIT || state_q == S_RELEASE;
        xbyte      = state_q == S_CMD   ? OPCODE
                   : state_q == S_ADDR2 ? addr_q[23:16]
                   : state_q == S_ADDR1 ? addr_q[15:8]
                   : state_q == S_ADDR0 ? addr_q[7:0]
                   : 8'h00;
        done_d     = (state_q == S_IDLE && start && count == 16'd0) || (state_q == S_RELEASE && xdone);
        addr_d     = (state_q == S_IDLE && start && count != 16'd0) ? addr : addr_q;
        cnt_d      = (state_q == S_IDLE && start && count != 16'd0) ? count
                   : (state_q == S_PUSH && word_ready) ? cnt_q - 16'd1
                   : cnt_q;
        word_d     = (state_q == S_RD_HI && xdone) ? {xrx, word_q[7:0]}
                   : (state_q == S_RD_LO && xdone) ? {word_q[15:8], xrx}
                   : word_q;
    end

    assign done     = done_q;
    assign word_out = word_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: randomized bench with an SPI engine + flash model and a queue-based reference
module tb_spi_flash_reader;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, word_ready = 1'b1;
    logic [23:0] addr = '0;
    logic [15:0] count = '0;
    logic        busy, done, word_valid, spi_load;
    logic [15:0] word_out, spi_in, spi_out;

    spi_flash_reader dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .count(count),
        .busy(busy), .done(done), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .spi_load(spi_load), .spi_in(spi_in), .spi_out(spi_out)
    );

    always #5 clk = ~clk;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    int total = 0, passed = 0;
    logic [7:0]  mem [int];
    logic [7:0]  mosi [$];
    logic [15:0] words [$];
    int n_load = 0, n_rel = 0, n_done = 0, busy_cnt = 0, idx = 0, bad_in = 0;
    bit busy_seen = 0;
    logic [23:0] fa = '0;
    logic [7:0]  rx = '0, spi_rx = '0;
    logic [15:0] last_in = '0;

    assign spi_out = {busy_cnt != 0, 7'd0, spi_rx};

    function automatic logic [7:0] fb(logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 8'((a[7:0] ^ a[15:8] ^ a[23:16]) * 37 + 11);
    endfunction

    // SPI engine + flash: 8 busy cycles per byte, flash auto-increments from the sent address
    always @(negedge clk) begin
        if (spi_load) begin
            n_load++;
            last_in = spi_in;
            if (spi_in[15:9] != 7'd0) bad_in++;
            if (spi_in[8]) begin
                n_rel++;
                idx = 0;
            end else begin
                mosi.push_back(spi_in[7:0]);
                if (idx >= 1 && idx <= 3) fa = {fa[15:0], spi_in[7:0]};
                rx = idx < HDR ? 8'hFF : fb(fa + 24'(idx - HDR));
                idx++;
                busy_cnt = 8;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) spi_rx = rx;
        end
        if (word_valid && word_ready) words.push_back(word_out);
        if (done) n_done++;
        if (busy) busy_seen = 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        mosi.delete();
        words.delete();
        n_load = 0; n_rel = 0; n_done = 0; bad_in = 0; busy_seen = 0;
    endtask

    task automatic run_req(input logic [23:0] a, input logic [15:0] c, input int stall, input int stall_at);
        logic [7:0]  eb [$];
        logic [15:0] ew [$];
        logic [15:0] snap;
        bit ok = 0, held = 0;
        int l0, chg, nb = 0, nw = 0;
        int budget = 140 + 15 * (6 + 2 * int'(c)) + 3 * stall * int'(c);
        clear_logs();
        eb.push_back(OPC); eb.push_back(a[23:16]); eb.push_back(a[15:8]); eb.push_back(a[7:0]);
        if (HDR == 5) eb.push_back(8'h00);
        for (int i = 0; i < int'(c); i++) begin
            eb.push_back(8'h00);
            eb.push_back(8'h00);
            ew.push_back({fb(a + 24'(2 * i)), fb(a + 24'(2 * i + 1))});
        end
        addr = a; count = c; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            if (stall_at >= 0 && !held && word_valid && words.size() == stall_at) begin
                word_ready = 1'b0; snap = word_out; l0 = n_load; chg = 0;
                repeat (20) begin
                    tick();
                    if (word_out !== snap || word_valid !== 1'b1) chg++;
                end
                total++;
                if (n_load != l0) $display("FAIL stall_load: %0d loads during stall, want 0", n_load - l0);
                else passed++;
                total++;
                if (chg != 0) $display("FAIL stall_hold: word_out/valid changed %0d times, want 0 (held %h)", chg, snap);
                else passed++;
                held = 1;
            end
            word_ready = $urandom_range(99) >= stall;
            start = busy && ($urandom_range(15) == 0);
            addr = 24'($urandom); count = 16'($urandom);
            tick();
            ok = n_done != 0;
        end
        start = 1'b0; word_ready = 1'b1;
        total++;
        if (!ok) $display("FAIL req_timeout: no done within %0d cycles (addr %h count %0d)", budget, a, c);
        else passed++;
        if (stall_at >= 0) begin
            total++;
            if (!held) $display("FAIL stall_reached: got held=0 want 1");
            else passed++;
        end
        for (int i = 0; i < eb.size(); i++) if (i >= mosi.size() || mosi[i] !== eb[i]) nb++;
        total++;
        if (nb != 0 || mosi.size() != eb.size())
            $display("FAIL mosi: %0d bytes differ, got %0d bytes (first %h) want %0d (first %h)",
                     nb, mosi.size(), mosi.size() ? mosi[0] : 8'hxx, eb.size(), eb[0]);
        else passed++;
        for (int i = 0; i < ew.size(); i++) if (i >= words.size() || words[i] !== ew[i]) nw++;
        total++;
        if (nw != 0 || words.size() != ew.size())
            $display("FAIL words: %0d differ, got %0d words (first %h) want %0d (first %h)",
                     nw, words.size(), words.size() ? words[0] : 16'hxxxx, ew.size(), ew[0]);
        else passed++;
        total++;
        if (n_rel != 1 || last_in !== 16'h0100) $display("FAIL release: got %0d releases last %h, want 1 and 0100", n_rel, last_in);
        else passed++;
        total++;
        if (n_load != eb.size() + 1) $display("FAIL load_count: got %0d want %0d", n_load, eb.size() + 1);
        else passed++;
        total++;
        if (bad_in != 0) $display("FAIL spi_in_upper: got %0d loads with nonzero [15:9], want 0", bad_in);
        else passed++;
        tick(); tick();
        total++;
        if (n_done != 1 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_pulse: got %0d pulses done=%b busy=%b, want 1, 0, 0", n_done, done, busy);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({busy, done, word_valid, spi_load} !== 4'b0) $display("FAIL reset_ctl: got %b want 0000", {busy, done, word_valid, spi_load});
        else passed++;
        total++;
        if (spi_in !== 16'h0 || word_out !== 16'h0) $display("FAIL reset_data: spi_in %h word_out %h, want 0000 0000", spi_in, word_out);
        else passed++;
        clear_logs();
        reset = 1'b0;
        tick(); tick();
        total++;
        if (n_rel != 1 || n_load != 1 || last_in !== 16'h0100)
            $display("FAIL init_release: got %0d loads %0d rel last %h, want 1 1 0100", n_load, n_rel, last_in);
        else passed++;
        repeat (10) tick();
        total++;
        if (n_load != 1 || busy !== 1'b0 || word_valid !== 1'b0)
            $display("FAIL init_idle: loads %0d busy %b valid %b, want 1 0 0", n_load, busy, word_valid);
        else passed++;
    endtask

    task automatic test_basic();
        mem[int'(24'h012345)] = 8'hA5;
        mem[int'(24'h012346)] = 8'h5A;
        run_req(24'h012345, 16'd1, 0, -1);
        total++;
        if (words.size() != 1 || words[0] !== 16'hA55A) $display("FAIL basic_word: got %h want a55a", words.size() ? words[0] : 16'hxxxx);
        else passed++;
    endtask

    task automatic test_backpressure();
        run_req(24'($urandom), 16'd3, 0, 1);
    endtask

    task automatic test_zero_count();
        clear_logs();
        addr = 24'($urandom); count = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0) $display("FAIL zero_done_len: got %b want 0", done);
        else passed++;
        repeat (8) tick();
        total++;
        if (n_load != 0 || busy_seen || n_done != 1)
            $display("FAIL zero_quiet: loads %0d busy_seen %0d pulses %0d, want 0 0 1", n_load, busy_seen, n_done);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        clear_logs();
        addr = 24'($urandom); count = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            tick();
            ok = mosi.size() >= 3;
        end
        total++;
        if (!ok) $display("FAIL reach_addr1: got %0d bytes want 3", mosi.size());
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, word_valid, spi_load} !== 4'b0 || spi_in !== 16'h0 || word_out !== 16'h0)
            $display("FAIL reset_async: ctl %b spi_in %h word %h, want 0000 0000 0000", {busy, done, word_valid, spi_load}, spi_in, word_out);
        else passed++;
        tick(); tick();
        clear_logs();
        reset = 1'b0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            ok = n_rel != 0;
        end
        total++;
        if (!ok || n_rel != 1 || last_in !== 16'h0100) $display("FAIL reinit_release: got %0d rel last %h, want 1 0100", n_rel, last_in);
        else passed++;
        total++;
        if (mosi.size() != 0) $display("FAIL reinit_bytes: got %0d bytes before release, want 0", mosi.size());
        else passed++;
        repeat (20) tick();
        total++;
        if (busy !== 1'b0 || n_load != 1) $display("FAIL reinit_idle: busy %b loads %0d, want 0 1", busy, n_load);
        else passed++;
        run_req(24'($urandom), 16'(1 + $urandom_range(3)), 20, -1);
    endtask

    task automatic test_fast_read();
        run_req(24'h000010, 16'd1, 0, -1);
    endtask

    task automatic test_random();
        run_req(24'hFFFFFC, 16'd4, 30, -1);
        for (int i = 0; i < 5; i++) run_req(24'($urandom), 16'($urandom_range(1, 6)), $urandom_range(0, 50), -1);
    endtask

    task automatic test_back_to_back();
        run_req(24'($urandom), 16'd2, 0, -1);
        run_req(24'($urandom), 16'd2, 0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_reset_mid();
        test_fast_read();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
